// File: rtl/performance_counter_if.sv
// performance_counter_if
//   Bundles the control inputs and result outputs of one performance counter.
//   master: control side, drives en/delta/clr and reads count/overflow.
//   slave : the counter itself.
//   en       - add delta on this edge
//   delta    - unsigned increment, DELTA_WIDTH bits
//   clr      - synchronous clear strobe
//   count    - registered accumulated value
//   overflow - sticky wrap/saturate flag
interface performance_counter_if #(
  parameter int COUNT_WIDTH = 64,
  parameter int DELTA_WIDTH = 3
);
  logic                   en;
  logic [DELTA_WIDTH-1:0] delta;
  logic                   clr;
  logic [COUNT_WIDTH-1:0] count;
  logic                   overflow;

  modport master (output en, delta, clr, input count, overflow);
  modport slave  (input en, delta, clr, output count, overflow);
endinterface

// File: rtl/performance_counter.sv
// performance_counter
//   Free-running event accumulator. On each clk edge with en high, the
//   zero-extended delta is added to count. clr zeroes count and overflow and
//   takes priority over en. SATURATE=0 wraps, SATURATE=1 holds at all-ones;
//   overflow is sticky until clr or reset.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - performance_counter_if slave modport (en, delta, clr, count, overflow)
//
//   The accumulator is split: the low DELTA_WIDTH+1 bits use a real adder,
//   the upper bits only ever increment by one on a carry. A second register
//   holds upper+1 ready in advance, so the carry merely selects between two
//   registered values and the wide increment never sits behind the adder.
module performance_counter #(
  parameter int COUNT_WIDTH = 64,
  parameter int DELTA_WIDTH = 3,
  parameter int SATURATE    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  performance_counter_if.slave bus
);
  localparam int LW = DELTA_WIDTH + 1;
  localparam int UW = COUNT_WIDTH - LW;

  logic [LW-1:0] lo_q;
  logic [LW:0]   lo_sum;
  logic          carry;
  logic          wrap;
  logic          ovf_q;

  always_comb begin
    lo_sum = {1'b0, lo_q} + {2'b00, bus.delta};
    carry  = lo_sum[LW];
  end

  generate
    if (UW > 0) begin : g_split
      logic [UW-1:0] hi_q;
      logic [UW-1:0] hi_inc_q;

      // A carry out of the full counter needs the upper part at all-ones.
      assign wrap = carry & (&hi_q);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hi_q     <= '0;
          hi_inc_q <= UW'(1);
        end else if (bus.clr) begin
          hi_q     <= '0;
          hi_inc_q <= UW'(1);
        end else if (bus.en) begin
          if ((SATURATE != 0) && wrap) begin
            hi_q     <= '1;
            hi_inc_q <= '0;
          end else if (carry) begin
            hi_q     <= hi_inc_q;
            hi_inc_q <= hi_inc_q + UW'(1);
          end
        end
      end

      assign bus.count = {hi_q, lo_q};
    end else begin : g_flat
      assign wrap      = carry;
      assign bus.count = lo_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q  <= '0;
      ovf_q <= 1'b0;
    end else if (bus.clr) begin
      lo_q  <= '0;
      ovf_q <= 1'b0;
    end else if (bus.en) begin
      if ((SATURATE != 0) && wrap) lo_q <= '1;
      else                         lo_q <= lo_sum[LW-1:0];
      if (wrap) ovf_q <= 1'b1;
    end
  end

  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_performance_counter.sv
// tb_performance_counter
//   Directed bench for performance_counter. Five instances share clk/rst_n:
//   64-bit wrap (main), 4-bit wrap, 4-bit saturate (no upper split), and
//   8-bit wrap / saturate (upper split reaches its top).
module tb_performance_counter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  longint unsigned model;
  logic [3:0] wide9;

  performance_counter_if #(.COUNT_WIDTH(64), .DELTA_WIDTH(3)) b64 ();
  performance_counter_if #(.COUNT_WIDTH(4),  .DELTA_WIDTH(3)) bw4 ();
  performance_counter_if #(.COUNT_WIDTH(4),  .DELTA_WIDTH(3)) bs4 ();
  performance_counter_if #(.COUNT_WIDTH(8),  .DELTA_WIDTH(3)) bw8 ();
  performance_counter_if #(.COUNT_WIDTH(8),  .DELTA_WIDTH(3)) bs8 ();

  performance_counter #(.COUNT_WIDTH(64), .DELTA_WIDTH(3), .SATURATE(0))
    u64 (.clk(clk), .rst_n(rst_n), .bus(b64));
  performance_counter #(.COUNT_WIDTH(4), .DELTA_WIDTH(3), .SATURATE(0))
    uw4 (.clk(clk), .rst_n(rst_n), .bus(bw4));
  performance_counter #(.COUNT_WIDTH(4), .DELTA_WIDTH(3), .SATURATE(1))
    us4 (.clk(clk), .rst_n(rst_n), .bus(bs4));
  performance_counter #(.COUNT_WIDTH(8), .DELTA_WIDTH(3), .SATURATE(0))
    uw8 (.clk(clk), .rst_n(rst_n), .bus(bw8));
  performance_counter #(.COUNT_WIDTH(8), .DELTA_WIDTH(3), .SATURATE(1))
    us8 (.clk(clk), .rst_n(rst_n), .bus(bs8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    wide9    = 4'd9;
    rst_n    = 1'b0;
    b64.en = 1'b1; b64.delta = 3'd7; b64.clr = 1'b0;
    bw4.en = 1'b1; bw4.delta = 3'd7; bw4.clr = 1'b0;
    bs4.en = 1'b1; bs4.delta = 3'd7; bs4.clr = 1'b0;
    bw8.en = 1'b1; bw8.delta = 3'd7; bw8.clr = 1'b0;
    bs8.en = 1'b1; bs8.delta = 3'd7; bs8.clr = 1'b0;

    // reset held with en=1, delta=7
    for (int i = 0; i < 5; i++) begin
      tick;
      check("rst_count64", b64.count, 64'd0);
      check("rst_ovf64", 64'(b64.overflow), 64'd0);
      check("rst_count_w4", 64'(bw4.count), 64'd0);
    end
    rst_n  = 1'b1;
    b64.en = 1'b0; bw4.en = 1'b0; bs4.en = 1'b0; bw8.en = 1'b0; bs8.en = 1'b0;
    tick;
    check("post_rst_count64", b64.count, 64'd0);

    // basic accumulate
    b64.en = 1'b1; b64.delta = 3'd4;
    tick; check("acc4", b64.count, 64'd4);
    b64.en = 1'b0;
    tick; check("idle_hold", b64.count, 64'd4);
    b64.delta = wide9[2:0];
    tick; check("en0_trunc_hold", b64.count, 64'd4);
    b64.en = 1'b1;
    tick; check("acc_trunc1", b64.count, 64'd5);
    b64.en = 1'b0;
    tick; check("hold5", b64.count, 64'd5);

    // clear, and clear beating en
    b64.clr = 1'b1;
    tick; check("clr", b64.count, 64'd0);
    b64.en = 1'b1; b64.delta = 3'd3;
    tick; check("clr_over_en", b64.count, 64'd0);
    check("clr_over_en_ovf", 64'(b64.overflow), 64'd0);
    b64.clr = 1'b0; b64.en = 1'b0;

    // 4-bit wrap and saturate
    bw4.en = 1'b1; bw4.delta = 3'd7; bs4.en = 1'b1; bs4.delta = 3'd7;
    tick; tick;
    check("w4_at14", 64'(bw4.count), 64'd14);
    check("s4_at14", 64'(bs4.count), 64'd14);
    check("w4_ovf_pre", 64'(bw4.overflow), 64'd0);
    bw4.delta = 3'd3; bs4.delta = 3'd3;
    tick;
    check("w4_wrap", 64'(bw4.count), 64'd1);
    check("w4_wrap_ovf", 64'(bw4.overflow), 64'd1);
    check("s4_sat", 64'(bs4.count), 64'd15);
    check("s4_sat_ovf", 64'(bs4.overflow), 64'd1);
    bw4.delta = 3'd1; bs4.delta = 3'd7;
    tick;
    check("w4_after_wrap", 64'(bw4.count), 64'd2);
    check("w4_ovf_sticky", 64'(bw4.overflow), 64'd1);
    check("s4_hold_max", 64'(bs4.count), 64'd15);
    check("s4_ovf_sticky", 64'(bs4.overflow), 64'd1);
    bw4.en = 1'b0; bs4.en = 1'b0; bw4.clr = 1'b1; bs4.clr = 1'b1;
    tick;
    check("w4_clr", 64'(bw4.count), 64'd0);
    check("w4_clr_ovf", 64'(bw4.overflow), 64'd0);
    check("s4_clr", 64'(bs4.count), 64'd0);
    check("s4_clr_ovf", 64'(bs4.overflow), 64'd0);
    bw4.clr = 1'b0; bs4.clr = 1'b0;

    // 8-bit: carries into the upper part, then wrap/saturate at the top
    bw8.en = 1'b1; bw8.delta = 3'd7; bs8.en = 1'b1; bs8.delta = 3'd7;
    tick; tick; tick;
    check("w8_21", 64'(bw8.count), 64'd21);
    repeat (32) tick;
    check("w8_245", 64'(bw8.count), 64'd245);
    check("s8_245", 64'(bs8.count), 64'd245);
    bw8.delta = 3'd5; bs8.delta = 3'd5;
    tick;
    check("w8_250", 64'(bw8.count), 64'd250);
    check("w8_250_ovf", 64'(bw8.overflow), 64'd0);
    bw8.delta = 3'd7; bs8.delta = 3'd7;
    tick;
    check("w8_wrap", 64'(bw8.count), 64'd1);
    check("w8_wrap_ovf", 64'(bw8.overflow), 64'd1);
    check("s8_sat", 64'(bs8.count), 64'd255);
    check("s8_sat_ovf", 64'(bs8.overflow), 64'd1);
    bw8.delta = 3'd1; bs8.delta = 3'd1;
    tick;
    check("w8_after_wrap", 64'(bw8.count), 64'd2);
    check("s8_hold_max", 64'(bs8.count), 64'd255);
    bw8.en = 1'b0; bs8.en = 1'b0;

    // async reset mid-run at count=1000
    b64.en = 1'b1; b64.delta = 3'd7;
    repeat (142) tick;
    b64.delta = 3'd6;
    tick;
    b64.en = 1'b0;
    check("reach1000", b64.count, 64'd1000);
    #3 rst_n = 1'b0;
    #1 check("async_rst_count", b64.count, 64'd0);
    check("async_rst_w8", 64'(bw8.count), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    check("after_async_rst", b64.count, 64'd0);

    // carry stress against a reference model
    model  = 0;
    b64.en = 1'b1; b64.delta = 3'd7;
    for (int i = 0; i < 10000; i++) begin
      tick;
      model = model + 7;
      check("stress", b64.count, model);
    end
    b64.en = 1'b0;
    check("stress_final", b64.count, 64'd70000);
    check("stress_ovf", 64'(b64.overflow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/performance_counter.md
Name: performance_counter

Overview:
- Free-running event accumulator for statistics and debug, e.g. packets or bytes per cycle on a 10GbE datapath at 312.5 MHz.
- Each clock where `en` is high, adds a small unsigned `delta` to a wide counter.
- Software or control logic reads `count` directly and clears it with a synchronous `clr` strobe.
- One instance is used per statistic, inside the switch's performance-monitoring block.

Parameters:
- COUNT_WIDTH, 64: width of the accumulator and of `count`; legal range 4..64.
- DELTA_WIDTH, 3: width of the `delta` input; must be less than COUNT_WIDTH.
- SATURATE, 0: 0 means the counter wraps modulo 2^COUNT_WIDTH; 1 means it holds at all-ones.

Ports:
- clk, in, 1: sole clock; all logic is rising-edge.
- rst_n, in, 1: asynchronous active-low reset; deassertion is synchronous to `clk` (external synchroniser).
- en, in, 1: when high, `delta` is added on this edge.
- delta, in, DELTA_WIDTH: unsigned increment, zero-extended; ignored when `en` is low.
- clr, in, 1: synchronous clear strobe, active-high.
- count, out, COUNT_WIDTH: current accumulated value, registered.
- overflow, out, 1: sticky flag, set when an add wrapped or saturated.

Behaviour:
- Reset: while `rst_n` is low, `count` = 0 and `overflow` = 0 immediately (asynchronous), regardless of clock. This also applies if reset is asserted mid-operation.
- Latency: single cycle. If `en`=1 with `delta`=d at edge N, then `count` = old + d after edge N. No internal pipeline is visible at the ports.
- `en`=0: `count` holds, whatever the value on `delta`.
- Width: `delta` is exactly DELTA_WIDTH bits; upper bits driven from a wider source are truncated by the connection (9 on a 3-bit port reads as 1). `delta`=0 with `en`=1 is a legal no-op.
- Priority at a clock edge: `rst_n` low > `clr` > `en`.
  - `clr`=1 gives `count` = 0 and `overflow` = 0 after the edge, even if `en`=1 on the same edge; that delta is discarded.
- Wrap, SATURATE=0: `count` = (old + d) mod 2^COUNT_WIDTH. `overflow` sets to 1 when a carry out of the MSB occurs.
- Saturate, SATURATE=1: if old + d > all-ones, `count` = all-ones and `overflow` sets to 1. Once at all-ones, further adds keep it there.
- `overflow` clears only on `clr` or `rst_n`.
- Timing: must close at 312.5 MHz with COUNT_WIDTH=64.
  - Implement the low DELTA_WIDTH+1 bits with a full adder.
  - Implement the upper bits as a conditional increment, using a precomputed upper+1 register selected by the carry, so the carry chain stays short.
  - The split must not change the cycle-level behaviour above.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold `rst_n`=0 with `en`=1, `delta`=7 for 5 clocks → `count`=0 and `overflow`=0 throughout. Release `rst_n` → still 0 until the first enabled edge.
- Basic accumulate:
  - `en`=1, `delta`=4 for one cycle → `count`=4 on the next cycle.
  - Idle 1 cycle, then `en`=0 with `delta`=1 (driven as 9, truncated) → `count` stays 4.
  - Then `en`=1, `delta`=1 for one cycle → `count`=5 and stays 5.
- Clear:
  - From `count`=5, pulse `clr` → `count`=0 next cycle.
  - Pulse `clr` and `en`=1/`delta`=3 on the same edge → `count`=0, not 3.
- Wrap (COUNT_WIDTH=4, SATURATE=0): accumulate to 14, then add 3 → `count`=1 and `overflow`=1. A further add of 1 → `count`=2, `overflow` still 1. `clr` → both 0.
- Saturate (COUNT_WIDTH=4, SATURATE=1): at 14, add 3 → `count`=15 and `overflow`=1. Add 7 → stays 15.
- Async reset mid-run: with `count`=1000, drop `rst_n` between clock edges → `count`=0 before the next edge.
- Carry stress (COUNT_WIDTH=64): `en`=1, `delta`=7 every cycle for 10,000 cycles → `count`=70,000, checked every cycle against a reference model.
